pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the core's in-order pipeline, the successor to the hard-wired per-stage registers (IF/ID, ID/EX, EX/MEM). It moves one control word and one data word per beat over a valid/ready handshake, with an optional skid entry for full throughput under backpressure. It also provides a squash (flush) path, a bus-wait freeze path, and cycle/retired-instruction counters. All stage boundaries in the core instantiate this block.

---
 rtl/pipe_stage_reg_if.sv | 29 ++
 rtl/pipe_stage_reg.sv | 150 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage boundary: the upstream offer/accept
// pair and the downstream present/accept pair, with their control and payload.
`timescale 1ns/1ps

interface pipe_stage_reg_if #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8
);
    logic              up_valid_i;
    logic              up_ready_o;
    logic [CTRL_W-1:0] up_ctrl_i;
    logic [DATA_W-1:0] up_data_i;
    logic              dn_valid_o;
    logic              dn_ready_i;
    logic [CTRL_W-1:0] dn_ctrl_o;
    logic [DATA_W-1:0] dn_data_o;

    // The stage register itself.
    modport slave (
        input  up_valid_i, up_ctrl_i, up_data_i, dn_ready_i,
        output up_ready_o, dn_valid_o, dn_ctrl_o, dn_data_o
    );

    // Whatever drives the stage from outside (neighbouring stages or a bench).
    modport master (
        output up_valid_i, up_ctrl_i, up_data_i, dn_ready_i,
        input  up_ready_o, dn_valid_o, dn_ctrl_o, dn_data_o
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// squash and freeze paths, and cycle / retired-beat counters.
`timescale 1ns/1ps

module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               freeze_i,
    input  logic               flush_i,
    pipe_stage_reg_if.slave    bus,
    output logic [CNT_W-1:0]   cycle_o,
    output logic [CNT_W-1:0]   instret_o
);

    // Occupancy encoded as {main_v, skid_v}; 2'b01 never occurs.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t              r_state,     w_state_nxt;
    logic [CTRL_W-1:0]   r_main_ctrl, w_main_ctrl_nxt;
    logic [DATA_W-1:0]   r_main_data, w_main_data_nxt;
    logic [CTRL_W-1:0]   r_skid_ctrl, w_skid_ctrl_nxt;
    logic [DATA_W-1:0]   r_skid_data, w_skid_data_nxt;
    logic [CNT_W-1:0]    r_cycle,     w_cycle_nxt;
    logic [CNT_W-1:0]    r_instret,   w_instret_nxt;

    logic w_main_v;
    logic w_skid_v;
    logic w_up_ready;
    logic w_dn_valid;
    logic w_up_fire;
    logic w_dn_fire;

    // Handshake qualifiers; freeze closes both sides so nothing can fire.
    always_comb begin
        w_main_v = (r_state != ST_EMPTY);
        w_skid_v = (r_state == ST_FULL);
        if (SKID != 0) begin
            // Ready depends only on a register: no path from dn_ready_i.
            w_up_ready = !w_skid_v && !freeze_i;
        end else begin
            w_up_ready = (!w_main_v || bus.dn_ready_i) && !freeze_i;
        end
        w_dn_valid = w_main_v && !freeze_i;
        w_up_fire  = bus.up_valid_i && w_up_ready && !flush_i;
        w_dn_fire  = w_dn_valid && bus.dn_ready_i;
    end

    assign bus.up_ready_o = w_up_ready;
    assign bus.dn_valid_o = w_dn_valid;
    assign bus.dn_ctrl_o  = w_dn_valid ? r_main_ctrl : '0;
    assign bus.dn_data_o  = r_main_data;
    assign cycle_o        = r_cycle;
    assign instret_o      = r_instret;

    // Next-state / next-entry computation; every default holds current state.
    always_comb begin
        w_state_nxt     = r_state;
        w_main_ctrl_nxt = r_main_ctrl;
        w_main_data_nxt = r_main_data;
        w_skid_ctrl_nxt = r_skid_ctrl;
        w_skid_data_nxt = r_skid_data;
        w_cycle_nxt     = r_cycle;
        w_instret_nxt   = r_instret;

        if (!freeze_i) begin
            w_cycle_nxt = r_cycle + CNT_ONE;
            if (flush_i) begin
                // Squash: drop both entries and the offered beat, keep payloads.
                w_state_nxt     = ST_EMPTY;
                w_main_ctrl_nxt = '0;
                w_skid_ctrl_nxt = '0;
            end else begin
                if (w_up_fire) begin
                    w_instret_nxt = r_instret + CNT_ONE;
                end
                unique case (r_state)
                    ST_EMPTY: begin
                        if (w_up_fire) begin
                            w_state_nxt     = ST_ONE;
                            w_main_ctrl_nxt = bus.up_ctrl_i;
                            w_main_data_nxt = bus.up_data_i;
                        end
                    end
                    ST_ONE: begin
                        if (w_up_fire && (w_dn_fire || SKID == 0)) begin
                            // Main drains and refills in the same edge.
                            w_main_ctrl_nxt = bus.up_ctrl_i;
                            w_main_data_nxt = bus.up_data_i;
                        end else if (w_up_fire) begin
                            // Downstream stalled: park the new beat behind main.
                            w_state_nxt     = ST_FULL;
                            w_skid_ctrl_nxt = bus.up_ctrl_i;
                            w_skid_data_nxt = bus.up_data_i;
                        end else if (w_dn_fire) begin
                            w_state_nxt     = ST_EMPTY;
                            w_main_ctrl_nxt = '0;
                        end
                    end
                    ST_FULL: begin
                        if (w_dn_fire) begin
                            // Older main has left; the skid beat becomes main.
                            w_state_nxt     = ST_ONE;
                            w_main_ctrl_nxt = r_skid_ctrl;
                            w_main_data_nxt = r_skid_data;
                            w_skid_ctrl_nxt = '0;
                        end
                    end
                    default: begin
                        w_state_nxt     = ST_EMPTY;
                        w_main_ctrl_nxt = '0;
                        w_skid_ctrl_nxt = '0;
                    end
                endcase
            end
        end
    end

    // State register; reset loads counters with all-ones so the first count is 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_EMPTY;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
            r_cycle     <= '1;
            r_instret   <= '1;
        end else begin
            r_state     <= w_state_nxt;
            r_main_ctrl <= w_main_ctrl_nxt;
            r_main_data <= w_main_data_nxt;
            r_skid_ctrl <= w_skid_ctrl_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_cycle     <= w_cycle_nxt;
            r_instret   <= w_instret_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance.
`timescale 1ns/1ps

module tb_pipe_stage_reg;
    localparam int DW = 96;
    localparam int CW = 8;
    localparam int NW = 64;
    localparam logic [NW-1:0] ONES = '1;

    logic          clk = 1'b0;
    logic          rst;
    logic          frz1, fl1, frz0, fl0;
    logic [NW-1:0] cyc1, ret1, cyc0, ret0;
    logic [NW-1:0] exp_cyc1, exp_cyc0;
    int            n_checks = 0;
    int            n_errors = 0;

    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus1 ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus0 ();

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .freeze_i(frz1), .flush_i(fl1),
        .bus(bus1.slave), .cycle_o(cyc1), .instret_o(ret1)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .freeze_i(frz0), .flush_i(fl0),
        .bus(bus0.slave), .cycle_o(cyc0), .instret_o(ret0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; keeps the expected cycle counts for both instances.
    task automatic tick();
        logic r, a1, a0;
        r  = rst;
        a1 = !frz1;
        a0 = !frz0;
        @(posedge clk);
        #1;
        if (r) begin
            exp_cyc1 = ONES;
            exp_cyc0 = ONES;
        end else begin
            if (a1) exp_cyc1 = exp_cyc1 + 64'd1;
            if (a0) exp_cyc0 = exp_cyc0 + 64'd1;
        end
    endtask

    task automatic up1(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        bus1.up_valid_i = v;
        bus1.up_ctrl_i  = c;
        bus1.up_data_i  = d;
    endtask

    task automatic up0(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        bus0.up_valid_i = v;
        bus0.up_ctrl_i  = c;
        bus0.up_data_i  = d;
    endtask

    initial begin
        rst = 1'b1;
        frz1 = 1'b0; fl1 = 1'b0; frz0 = 1'b0; fl0 = 1'b0;
        exp_cyc1 = ONES; exp_cyc0 = ONES;
        up1(1'b0, '0, '0); bus1.dn_ready_i = 1'b0;
        up0(1'b0, '0, '0); bus0.dn_ready_i = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_dn_valid", 128'(bus1.dn_valid_o), 128'd0);
        chk("rst_dn_ctrl",  128'(bus1.dn_ctrl_o),  128'd0);
        chk("rst_dn_data",  128'(bus1.dn_data_o),  128'd0);
        chk("rst_cycle",    128'(cyc1), 128'(ONES));
        chk("rst_instret",  128'(ret1), 128'(ONES));
        chk("rst_up_ready", 128'(bus1.up_ready_o), 128'd1);

        // Idle after reset: cycle counts 0,1,2,3
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_cycle", 128'(cyc1), 128'(i));
            chk("idle_instret", 128'(ret1), 128'(ONES));
            chk("idle_dn_valid", 128'(bus1.dn_valid_o), 128'd0);
            chk("idle_dn_ctrl", 128'(bus1.dn_ctrl_o), 128'd0);
        end

        // Five back-to-back beats, downstream always ready
        bus1.dn_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            up1(1'b1, CW'(i + 1), DW'(16 + i));
            #1;
            chk("stream_up_ready", 128'(bus1.up_ready_o), 128'd1);
            tick();
            chk("stream_dn_valid", 128'(bus1.dn_valid_o), 128'd1);
            chk("stream_dn_data", 128'(bus1.dn_data_o), 128'(16 + i));
            chk("stream_dn_ctrl", 128'(bus1.dn_ctrl_o), 128'(i + 1));
        end
        chk("stream_instret", 128'(ret1), 128'd4);
        up1(1'b0, '0, '0);
        tick();
        chk("drain_dn_valid", 128'(bus1.dn_valid_o), 128'd0);
        chk("drain_dn_ctrl", 128'(bus1.dn_ctrl_o), 128'd0);
        chk("drain_dn_data_hold", 128'(bus1.dn_data_o), 128'h14);
        chk("drain_cycle", 128'(cyc1), 128'd9);

        // Backpressure: 0xA then 0xB fill the stage
        bus1.dn_ready_i = 1'b0;
        up1(1'b1, 8'h21, 96'hA);
        tick();
        chk("bp_one_data", 128'(bus1.dn_data_o), 128'hA);
        chk("bp_one_ready", 128'(bus1.up_ready_o), 128'd1);
        up1(1'b1, 8'h22, 96'hB);
        tick();
        chk("bp_full_ready", 128'(bus1.up_ready_o), 128'd0);
        chk("bp_full_data", 128'(bus1.dn_data_o), 128'hA);
        up1(1'b0, '0, '0);
        bus1.dn_ready_i = 1'b1;
        #1;
        chk("bp_ready_no_comb", 128'(bus1.up_ready_o), 128'd0);
        chk("bp_first_ctrl", 128'(bus1.dn_ctrl_o), 128'h21);
        tick();
        chk("bp_second_data", 128'(bus1.dn_data_o), 128'hB);
        chk("bp_second_ctrl", 128'(bus1.dn_ctrl_o), 128'h22);
        chk("bp_ready_back", 128'(bus1.up_ready_o), 128'd1);
        tick();
        chk("bp_empty_valid", 128'(bus1.dn_valid_o), 128'd0);
        chk("bp_instret", 128'(ret1), 128'd6);
        chk("bp_cycle", 128'(cyc1), 128'd13);

        // Flush while FULL, with a beat offered carrying ctrl 0xFF
        bus1.dn_ready_i = 1'b0;
        up1(1'b1, 8'h31, 96'hC);
        tick();
        up1(1'b1, 8'h32, 96'hD);
        tick();
        chk("fl_pre_ready", 128'(bus1.up_ready_o), 128'd0);
        up1(1'b1, 8'hFF, 96'hEE);
        fl1 = 1'b1;
        tick();
        fl1 = 1'b0;
        up1(1'b0, '0, '0);
        chk("fl_dn_valid", 128'(bus1.dn_valid_o), 128'd0);
        chk("fl_dn_ctrl", 128'(bus1.dn_ctrl_o), 128'd0);
        chk("fl_data_kept", 128'(bus1.dn_data_o), 128'hC);
        chk("fl_instret", 128'(ret1), 128'd8);
        chk("fl_cycle", 128'(cyc1), 128'd16);
        chk("fl_up_ready", 128'(bus1.up_ready_o), 128'd1);

        // Flush with a beat offered into an empty stage: beat dropped
        up1(1'b1, 8'hFF, 96'h55);
        fl1 = 1'b1;
        tick();
        fl1 = 1'b0;
        up1(1'b0, '0, '0);
        chk("fle_dn_valid", 128'(bus1.dn_valid_o), 128'd0);
        chk("fle_instret", 128'(ret1), 128'd8);

        // Freeze for 3 cycles with a held beat and a new beat offered
        up1(1'b1, 8'h41, 96'h77);
        tick();
        chk("frz_load_instret", 128'(ret1), 128'd9);
        up1(1'b1, 8'h42, 96'h78);
        bus1.dn_ready_i = 1'b1;
        frz1 = 1'b1;
        #1;
        chk("frz_dn_valid", 128'(bus1.dn_valid_o), 128'd0);
        chk("frz_dn_ctrl", 128'(bus1.dn_ctrl_o), 128'd0);
        chk("frz_up_ready", 128'(bus1.up_ready_o), 128'd0);
        tick();
        fl1 = 1'b1;
        tick();
        fl1 = 1'b0;
        tick();
        chk("frz_cycle_held", 128'(cyc1), 128'(exp_cyc1));
        chk("frz_cycle_abs", 128'(cyc1), 128'd18);
        chk("frz_instret_held", 128'(ret1), 128'd9);
        chk("frz_data_held", 128'(bus1.dn_data_o), 128'h77);
        frz1 = 1'b0;
        #1;
        chk("thaw_dn_valid", 128'(bus1.dn_valid_o), 128'd1);
        chk("thaw_up_ready", 128'(bus1.up_ready_o), 128'd1);
        tick();
        chk("thaw_dn_data", 128'(bus1.dn_data_o), 128'h78);
        chk("thaw_dn_ctrl", 128'(bus1.dn_ctrl_o), 128'h42);
        chk("thaw_instret", 128'(ret1), 128'd10);
        chk("thaw_cycle", 128'(cyc1), 128'(exp_cyc1));
        up1(1'b0, '0, '0);
        tick();
        chk("thaw_empty", 128'(bus1.dn_valid_o), 128'd0);

        // SKID=0: combinational ready follows dn_ready_i when main is valid
        up0(1'b1, 8'h51, 96'h100);
        #1;
        chk("s0_ready_empty", 128'(bus0.up_ready_o), 128'd1);
        tick();
        chk("s0_dn_valid", 128'(bus0.dn_valid_o), 128'd1);
        chk("s0_dn_data", 128'(bus0.dn_data_o), 128'h100);
        up0(1'b1, 8'h52, 96'h101);
        #1;
        chk("s0_ready_stall", 128'(bus0.up_ready_o), 128'd0);
        tick();
        chk("s0_stall_data", 128'(bus0.dn_data_o), 128'h100);
        bus0.dn_ready_i = 1'b1;
        #1;
        chk("s0_ready_comb", 128'(bus0.up_ready_o), 128'd1);
        tick();
        chk("s0_replace_data", 128'(bus0.dn_data_o), 128'h101);
        chk("s0_replace_ctrl", 128'(bus0.dn_ctrl_o), 128'h52);
        chk("s0_replace_valid", 128'(bus0.dn_valid_o), 128'd1);
        up0(1'b0, '0, '0);
        tick();
        chk("s0_drain_valid", 128'(bus0.dn_valid_o), 128'd0);
        chk("s0_drain_ctrl", 128'(bus0.dn_ctrl_o), 128'd0);
        chk("s0_instret", 128'(ret0), 128'd1);
        chk("s0_cycle", 128'(cyc0), 128'(exp_cyc0));

        // Reset mid-operation with a beat held and another offered
        bus1.dn_ready_i = 1'b0;
        up1(1'b1, 8'h61, 96'h99);
        tick();
        chk("mrst_pre_valid", 128'(bus1.dn_valid_o), 128'd1);
        rst = 1'b1;
        tick();
        chk("mrst_dn_valid", 128'(bus1.dn_valid_o), 128'd0);
        chk("mrst_dn_ctrl", 128'(bus1.dn_ctrl_o), 128'd0);
        chk("mrst_dn_data", 128'(bus1.dn_data_o), 128'd0);
        chk("mrst_cycle", 128'(cyc1), 128'(ONES));
        chk("mrst_instret", 128'(ret1), 128'(ONES));
        chk("mrst_cycle0", 128'(cyc0), 128'(ONES));
        rst = 1'b0;
        up1(1'b0, '0, '0);
        tick();
        chk("mrst_after_cycle", 128'(cyc1), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
